// File: rtl/vtg_pkg.sv
// Shared types and constants for the video timing generator.
package vtg_pkg;

  localparam int CNT_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  localparam logic [23:0] C_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] C_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] C_CYAN    = 24'h00FFFF;
  localparam logic [23:0] C_GREEN   = 24'h00FF00;
  localparam logic [23:0] C_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] C_RED     = 24'hFF0000;
  localparam logic [23:0] C_BLUE    = 24'h0000FF;
  localparam logic [23:0] C_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_color(
    input logic [2:0] idx
  );
    logic [23:0] c;
    unique case (idx)
      3'd0: c = C_WHITE;
      3'd1: c = C_YELLOW;
      3'd2: c = C_CYAN;
      3'd3: c = C_GREEN;
      3'd4: c = C_MAGENTA;
      3'd5: c = C_RED;
      3'd6: c = C_BLUE;
      3'd7: c = C_BLACK;
      default: c = C_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// One raster axis: position counter with active and sync window decode.
module vtg_axis_counter
  import vtg_pkg::*;
#(
  parameter int ACTIVE = 1280,
  parameter int FP     = 110,
  parameter int SYNC   = 40,
  parameter int BP     = 220
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             adv_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o,
  output logic             active_o,
  output logic             sync_o
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam int S_BEG = ACTIVE + FP;
  localparam int S_END = S_BEG + SYNC;

  // Compare one bit wider so a 4096 boundary does not alias to 0.
  localparam logic [CNT_W:0] LAST_L = (CNT_W+1)'(TOTAL - 1);
  localparam logic [CNT_W:0] ACT_L  = (CNT_W+1)'(ACTIVE);
  localparam logic [CNT_W:0] SBEG_L = (CNT_W+1)'(S_BEG);
  localparam logic [CNT_W:0] SEND_L = (CNT_W+1)'(S_END);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W:0]   cnt_w;
  logic             last;

  always_comb begin
    cnt_w    = {1'b0, cnt_q};
    last     = (cnt_w == LAST_L);
    wrap_o   = adv_i && last && !clr_i;
    active_o = (cnt_w < ACT_L);
    sync_o   = (cnt_w >= SBEG_L) && (cnt_w < SEND_L);
    cnt_d    = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (adv_i) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing source: hs/vs/de, frame-start pulse and frame counter.
// Optional colour-bar output under VIDEO_TIMING_GEN_TEST_PATTERN_EN.
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 110,
  parameter int   H_SYNC   = 40,
  parameter int   H_BP     = 220,
  parameter int   V_ACTIVE = 720,
  parameter int   V_FP     = 5,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 20,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic             hs_o,
  output logic             vs_o,
  output logic             de_o,
  output logic             fs_o,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o,
  output logic             busy_o,
  output logic [15:0]      frame_cnt_o
`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
  ,
  output logic [23:0]      rgb_o
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);

  if (H_TOTAL > 4096) begin : g_h_chk
    $error("H_TOTAL exceeds 4096");
  end
  if (V_TOTAL > 4096) begin : g_v_chk
    $error("V_TOTAL exceeds 4096");
  end

  state_e state_q, state_d;

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic h_wrap, h_act, h_sync;
  logic v_wrap, v_act, v_sync;
  logic run;

  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             de_q, de_d;
  logic             fs_q, fs_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             busy_q, busy_d;
  logic             last_q, last_d;
  logic [15:0]      fc_q, fc_d;

  vtg_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (!run),
    .adv_i    (1'b1),
    .cnt_o    (h_cnt),
    .wrap_o   (h_wrap),
    .active_o (h_act),
    .sync_o   (h_sync)
  );

  vtg_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (!run),
    .adv_i    (h_wrap),
    .cnt_o    (v_cnt),
    .wrap_o   (v_wrap),
    .active_o (v_act),
    .sync_o   (v_sync)
  );

  assign run = (state_q != IDLE);

  // Stop requests only take effect once the frame in flight finishes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en_i) state_d = RUN;
      RUN:     if (!en_i) state_d = DRAIN;
      DRAIN: begin
        if (en_i) state_d = RUN;
        else if (v_wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    de_d   = run && h_act && v_act;
    hs_d   = (run && h_sync) ? HS_POL : ~HS_POL;
    vs_d   = (run && v_sync) ? VS_POL : ~VS_POL;
    fs_d   = run && (h_cnt == '0) && (v_cnt == VS_BEG);
    x_d    = de_d ? h_cnt : '0;
    y_d    = de_d ? v_cnt : '0;
    busy_d = run;
    last_d = run && v_wrap;
    fc_d   = last_q ? fc_q + 16'd1 : fc_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
      x_q     <= x_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      fc_q    <= fc_d;
    end
  end

  assign hs_o        = hs_q;
  assign vs_o        = vs_q;
  assign de_o        = de_q;
  assign fs_o        = fs_q;
  assign x_o         = x_q;
  assign y_o         = y_q;
  assign busy_o      = busy_q;
  assign frame_cnt_o = fc_q;

`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [CNT_W-1:0] bar_idx;
  logic [23:0]      rgb_q, rgb_d;

  // Pixels past the eighth full bar fall into the last (black) bar.
  always_comb begin
    bar_idx = h_cnt / CNT_W'(BAR_W);
    rgb_d   = '0;
    if (de_d) begin
      rgb_d = (bar_idx > CNT_W'(7)) ? C_BLACK : bar_color(bar_idx[2:0]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign rgb_o = rgb_q;
`endif

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Source side of the frame-sync path. Generates hs/vs/de raster timing for the video DMA write path and downstream display/capture logic, plus a one-cycle frame-start pulse aligned to each vs assertion. Start/stop is controlled by an enable that only takes effect on frame boundaries, so frames are never truncated.

Parameters:
H_ACTIVE, 1280, active pixels per line
H_FP, 110, horizontal front porch (clocks)
H_SYNC, 40, hsync width (clocks)
H_BP, 220, horizontal back porch (clocks)
V_ACTIVE, 720, active lines per frame
V_FP, 5, vertical front porch (lines)
V_SYNC, 5, vsync width (lines)
V_BP, 20, vertical back porch (lines)
HS_POL, 1, hsync active level (1 = active-high)
VS_POL, 1, vsync active level (1 = active-high)

Ports:
clk_i  in  1  pixel clock
rst_i  in  1  reset
en_i  in  1  run request (level)
hs_o  out  1  horizontal sync
vs_o  out  1  vertical sync
de_o  out  1  data enable, high during active pixels
fs_o  out  1  one-cycle pulse on the first cycle vs_o is active
x_o  out  12  active pixel column; 0 when de_o low
y_o  out  12  active line index; 0 when de_o low
busy_o  out  1  high in RUN or DRAIN
frame_cnt_o  out  16  completed frames, wraps at 0xFFFF->0

Behaviour:
- Interface: one clock (clk_i); reset rst_i is synchronous and active-high.
- H_TOTAL = sum of H_* timings and V_TOTAL = sum of V_* timings; both must be <= 4096 (elaboration assertion).
- Counters h_cnt 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1. v_cnt advances when h_cnt wraps.
- Line order: active [0,H_ACTIVE), FP, sync, BP. Frame order is the same using V_* and v_cnt.
- hs active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC. vs active when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for the whole line, so vs changes only at h_cnt=0.
- All outputs are registered from the counters, with one cycle of latency. hs_o, vs_o, de_o, x_o and y_o are always mutually consistent.
- FSM states:
  - IDLE -> RUN when en_i=1. Counters are loaded to 0,0 on that cycle.
  - RUN -> DRAIN when en_i=0.
  - DRAIN -> RUN when en_i=1, with no counter disturbance.
  - DRAIN -> IDLE on the last pixel of the frame (h=H_TOTAL-1, v=V_TOTAL-1).
  - RUN wraps frames continuously.
- Start latency: en_i sampled high in IDLE at cycle N gives counters 0,0 at N+1, and de_o=1, x_o=0, y_o=0 at N+2.
- In IDLE: hs_o=~HS_POL, vs_o=~VS_POL, de_o=0, fs_o=0, x_o=y_o=0, busy_o=0. Counters are held at 0.
- fs_o is high for exactly one cycle, on the same cycle vs_o first goes active in each frame. It fires in RUN and in DRAIN.
- frame_cnt_o increments by 1 on the cycle after the last pixel of a frame is output (RUN or DRAIN).
- Reset values (any state, including mid-frame): state IDLE, counters 0, frame_cnt_o=0, all other outputs at their IDLE values, effective on the next edge.
- en_i toggling within a frame produces no visible change provided it ends high before the frame's last pixel.

Optional Feature:
Macro VIDEO_TIMING_GEN_TEST_PATTERN_EN.
- Defined: adds output rgb_o[23:0], registered and aligned with de_o.
  - Shows 8 vertical colour bars in order: white, yellow, cyan, green, magenta, red, blue, black.
  - Bar width = H_ACTIVE/8 (integer division); remainder pixels take the last bar colour.
  - rgb_o = 0 when de_o low.
- Not defined: port absent, no pattern logic.

Decomposition:
- Package vtg_pkg holds:
  - CNT_W=12
  - FSM state enum (IDLE, RUN, DRAIN)
  - 24-bit colour bar constants
- One sub-module, vtg_axis_counter, instantiated for the horizontal and vertical axes. Parameters: ACTIVE, FP, SYNC, BP.
  - Outputs: cnt, wrap, active, sync.
  - Advance input: constant 1 for the horizontal axis, h wrap for the vertical axis.

Test Plan:
Bench parameters: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2 (H_TOTAL=14); V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=7); frame = 98 clocks.
1. Reset, then en_i=1 at cycle N -> de_o=1, x_o=0, y_o=0 at N+2; de_o high 8 clocks per line; hs_o high at x positions 10..11.
2. Continuous run -> vs_o high for exactly 14 clocks starting line 5; fs_o pulses once per 98 clocks, coincident with the vs_o rise; frame_cnt_o = 3 after 3 full frames.
3. en_i dropped mid-frame -> frame completes (all 4 active lines seen); busy_o falls and outputs go idle after the last pixel; frame_cnt_o +1.
4. en_i dropped then re-raised within the same frame -> no gap; next frame starts on time with no extra idle cycles.
5. rst_i asserted mid-active-line -> next cycle de_o=0, frame_cnt_o=0, hs_o/vs_o inactive; restart obeys the N+2 latency.
6. With VIDEO_TIMING_GEN_TEST_PATTERN_EN defined -> rgb_o = FFFFFF at x=0, FFFF00 at x=1, 000000 at x=7, and 0 outside de_o.
